// File: rtl/e_mdu_if.sv
// Bus between the execute stage and the multiply/divide unit.
interface e_mdu_if;
    logic [3:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        start;
    logic        busy;
    logic [31:0] rd;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: presents the op and forwarded operands.
    modport master (
        output mdu_op, A, B, req,
        input  start, busy, rd, hi, lo
    );

    // MDU side.
    modport slave (
        input  mdu_op, A, B, req,
        output start, busy, rd, hi, lo
    );
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// Results are computed at the start edge and published after a fixed latency.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  bus
);
    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
    localparam logic [CntW-1:0] OneCnt  = CntW'(1);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    typedef enum logic [0:0] {StIdle, StCalc} state_t;

    state_t          state;
    logic [CntW-1:0] counter;
    logic            busy_reg;
    logic [31:0]     hi_val;
    logic [31:0]     lo_val;
    logic [31:0]     temp_hi;
    logic [31:0]     temp_lo;
    logic            temp_wr;

    logic            calc_op;
    logic            start;
    logic [63:0]     mul_s;
    logic [63:0]     mul_u;
    logic [31:0]     a_abs;
    logic [31:0]     b_abs;
    logic [31:0]     num;
    logic [31:0]     den;
    logic [31:0]     q_u;
    logic [31:0]     r_u;
    logic [31:0]     quot;
    logic [31:0]     rem;

    assign calc_op = (bus.mdu_op >= OpMult) && (bus.mdu_op <= OpDivu);
    assign start   = calc_op && !busy_reg && !bus.req;

    assign bus.start = start;
    assign bus.busy  = busy_reg;
    assign bus.hi    = hi_val;
    assign bus.lo    = lo_val;

    // Read port for mfhi/mflo; zero for every other op.
    always_comb begin
        bus.rd = 32'd0;
        if (bus.mdu_op == OpMfhi) begin
            bus.rd = hi_val;
        end else if (bus.mdu_op == OpMflo) begin
            bus.rd = lo_val;
        end
    end

    // Full-width results from the live operands; only sampled on the start edge.
    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        mul_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
        mul_u = {32'd0, bus.A} * {32'd0, bus.B};
        a_abs = bus.A[31] ? (32'd0 - bus.A) : bus.A;
        b_abs = bus.B[31] ? (32'd0 - bus.B) : bus.B;
        num   = (bus.mdu_op == OpDiv) ? a_abs : bus.A;
        den   = (bus.mdu_op == OpDiv) ? b_abs : bus.B;
        // Divisor forced non-zero; divide-by-zero results are never written.
        if (den == 32'd0) begin
            den = 32'd1;
        end
        q_u  = num / den;
        r_u  = num % den;
        quot = q_u;
        rem  = r_u;
        if (bus.mdu_op == OpDiv) begin
            quot = (bus.A[31] ^ bus.B[31]) ? (32'd0 - q_u) : q_u;
            rem  = bus.A[31] ? (32'd0 - r_u) : r_u;
        end
    end

    // Control FSM, latency counter, pending result and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= StIdle;
            counter  <= '0;
            busy_reg <= 1'b0;
            hi_val   <= 32'd0;
            lo_val   <= 32'd0;
            temp_hi  <= 32'd0;
            temp_lo  <= 32'd0;
            temp_wr  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        state    <= StCalc;
                        if (bus.mdu_op == OpMult || bus.mdu_op == OpMultu) begin
                            counter <= MultCnt;
                            temp_wr <= 1'b1;
                            {temp_hi, temp_lo} <= (bus.mdu_op == OpMult) ? mul_s : mul_u;
                        end else begin
                            counter <= DivCnt;
                            temp_wr <= (bus.B != 32'd0);
                            temp_hi <= rem;
                            temp_lo <= quot;
                        end
                    end else if (!bus.req && bus.mdu_op == OpMthi) begin
                        hi_val <= bus.A;
                    end else if (!bus.req && bus.mdu_op == OpMtlo) begin
                        lo_val <= bus.A;
                    end
                end
                StCalc: begin
                    if (counter == OneCnt) begin
                        if (temp_wr) begin
                            hi_val <= temp_hi;
                            lo_val <= temp_lo;
                        end
                        busy_reg <= 1'b0;
                        counter  <= '0;
                        state    <= StIdle;
                    end else begin
                        counter <= counter - OneCnt;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: arithmetic, latency, req suppression, reset abort.
module tb_e_mdu;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    e_mdu_if bus ();

    e_mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive an op at the falling edge and let combinational outputs settle.
    task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.mdu_op = op;
        bus.A      = a;
        bus.B      = b;
        #1;
    endtask

    // Take the rising edge, then clear the op and scramble the operands.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.mdu_op = 4'd0;
        bus.A      = 32'hA5A5_5A5A;
        bus.B      = 32'h0F0F_F0F0;
    endtask

    // Count falling edges with busy high; gives up after 50.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cycles++;
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        present(op, a, b);
        tick();
        wait_idle(cycles);
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        bus.mdu_op = 4'd1;
        bus.A      = 32'd3;
        bus.B      = 32'd4;
        bus.req    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b hi=%h lo=%h required 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        bus.mdu_op = 4'd0;
        reset      = 1'b1;
    endtask

    task automatic test_mult();
        int n;
        present(4'd1, 32'hFFFF_FFFE, 32'd3);
        checks++;
        if (bus.start !== 1'b1) begin
            errors++;
            $display("FAIL mult_start got %b required 1", bus.start);
        end
        tick();
        checks++;
        if (bus.start !== 1'b0 || bus.busy !== 1'b1 || bus.hi !== 32'd0) begin
            errors++;
            $display("FAIL mult_issue start=%b busy=%b hi=%h required 0/1/0", bus.start, bus.busy,
                     bus.hi);
        end
        wait_idle(n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL mult_latency got %0d required 5", n);
        end
        checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult_result hi=%h lo=%h required ffffffff/fffffffa", bus.hi, bus.lo);
        end
        bus.mdu_op = 4'd6;
        #1;
        checks++;
        if (bus.rd !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mflo_rd got %h required fffffffa", bus.rd);
        end
        bus.mdu_op = 4'd0;
    endtask

    task automatic test_multu();
        int n;
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        checks++;
        if (n != 5 || bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu n=%0d hi=%h lo=%h required 5/fffffffe/00000001", n, bus.hi, bus.lo);
        end
    endtask

    task automatic test_div();
        int n;
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n);
        checks++;
        if (n != 10 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_neg n=%0d hi=%h lo=%h required 10/ffffffff/fffffffd", n, bus.hi, bus.lo);
        end
        run_op(4'd4, 32'hFFFF_FFF9, 32'd2, n);
        checks++;
        if (n != 10 || bus.lo !== 32'h7FFF_FFFC || bus.hi !== 32'd1) begin
            errors++;
            $display("FAIL divu n=%0d hi=%h lo=%h required 10/00000001/7ffffffc", n, bus.hi, bus.lo);
        end
        run_op(4'd3, 32'd7, 32'hFFFF_FFFE, n);
        checks++;
        if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'd1) begin
            errors++;
            $display("FAIL div_negdivisor hi=%h lo=%h required 00000001/fffffffd", bus.hi, bus.lo);
        end
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++;
        if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin
            errors++;
            $display("FAIL div_overflow hi=%h lo=%h required 00000000/80000000", bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_zero();
        int n;
        present(4'd7, 32'h1234_5678, 32'd0);
        tick();
        checks++;
        if (bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi hi=%h busy=%b required 12345678/0", bus.hi, bus.busy);
        end
        run_op(4'd4, 32'd99, 32'd0, n);
        checks++;
        if (n != 10 || bus.hi !== 32'h1234_5678 || bus.lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL divu_zero n=%0d hi=%h lo=%h required 10/12345678/80000000", n, bus.hi,
                     bus.lo);
        end
        bus.mdu_op = 4'd5;
        #1;
        checks++;
        if (bus.rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mfhi_rd got %h required 12345678", bus.rd);
        end
        bus.mdu_op = 4'd0;
    endtask

    task automatic test_req();
        int n;
        bus.req = 1'b1;
        present(4'd1, 32'd9, 32'd9);
        checks++;
        if (bus.start !== 1'b0) begin
            errors++;
            $display("FAIL req_start got %b required 0", bus.start);
        end
        tick();
        present(4'd7, 32'hDEAD_BEEF, 32'd0);
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h1234_5678 || bus.lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL req_suppress busy=%b hi=%h lo=%h required 0/12345678/80000000", bus.busy,
                     bus.hi, bus.lo);
        end
        bus.req = 1'b0;
        present(4'd1, 32'd5, 32'd7);
        tick();
        n = 0;
        @(negedge clk);
        if (bus.busy) n++;
        @(negedge clk);
        if (bus.busy) n++;
        bus.req = 1'b1;
        @(negedge clk);
        if (bus.busy) n++;
        // Illegal while busy: must be ignored.
        bus.mdu_op = 4'd8;
        bus.A      = 32'h0000_FFFF;
        @(negedge clk);
        if (bus.busy) n++;
        bus.mdu_op = 4'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        bus.req = 1'b0;
        checks++;
        if (n != 5 || bus.hi !== 32'd0 || bus.lo !== 32'd35) begin
            errors++;
            $display("FAIL req_no_cancel n=%0d hi=%h lo=%h required 5/00000000/00000023", n, bus.hi,
                     bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        run_op(4'd1, 32'd6, 32'd7, n);
        checks++;
        if (bus.lo !== 32'd42) begin
            errors++;
            $display("FAIL b2b_first lo=%h required 0000002a", bus.lo);
        end
        bus.mdu_op = 4'd2;
        bus.A      = 32'd3;
        bus.B      = 32'd4;
        #1;
        checks++;
        if (bus.start !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start got %b required 1", bus.start);
        end
        tick();
        wait_idle(n);
        checks++;
        if (n != 5 || bus.lo !== 32'd12 || bus.hi !== 32'd0) begin
            errors++;
            $display("FAIL b2b_second n=%0d hi=%h lo=%h required 5/00000000/0000000c", n, bus.hi,
                     bus.lo);
        end
    endtask

    task automatic test_reset_mid();
        present(4'd3, 32'd100, 32'd7);
        tick();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%b hi=%h lo=%h required 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_discard busy=%b hi=%h lo=%h required 0/0/0", bus.busy, bus.hi,
                     bus.lo);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_req();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
